// File: rtl/debounce_sync.sv
// debounce_sync: synchronizer chain followed by a counter-based debounce FSM.
// Produces a clean registered level q plus optional one-cycle rise/fall strobes.
// Build option: define DEBOUNCE_SYNC_EDGE_EN to compile in the rise/fall strobe
// registers; without it both strobe ports are tied to 1'b0.
// Handshake: none. d_in is a free-running level; q/rise/fall are plain
// registered outputs with no valid/ready qualification.
module debounce_sync #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    localparam state_e ST_RESET = RESET_LEVEL ? ST_HI : ST_LO;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          cnt_inc;
    logic                   q_q, q_d;

    // Synchronizer chain: d_in enters at bit 0, s is the last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The counter is always zero in the stable states, so the same increment
    // serves the first qualifying edge (including the DEBOUNCE_CYCLES=1 case).
    assign cnt_inc = cnt_q + CNT_ONE;

    // Next-state logic: qualify a new level of s for DEBOUNCE_CYCLES edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        unique case (state_q)
            ST_LO: begin
                if (s) begin
                    if (cnt_inc == CNT_MAX) begin
                        state_d = ST_HI;
                        q_d     = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = ST_HI;
                    q_d     = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HI: begin
                if (!s) begin
                    if (cnt_inc == CNT_MAX) begin
                        state_d = ST_LO;
                        q_d     = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = ST_LO;
                    q_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, qualification counter and debounced level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            q_q     <= RESET_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign q = q_q;

`ifdef DEBOUNCE_SYNC_EDGE_EN
    logic rise_q, fall_q;

    // Strobes register alongside q, so they are high exactly in the cycle q changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= q_d & ~q_q;
            fall_q <= ~q_d & q_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
